fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the pipelined RV32I core; sits directly upstream of the control unit's main decoder. Owns the program counter, drives the instruction-memory address, and captures fetched instructions into the IF/ID pipeline register that feeds decode. Handles stall from the hazard unit and PC redirection (taken branch, JAL, JALR) from execute, inserting bubbles as required.

## Interface
- ADDR_WIDTH, 32, PC / instruction-memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (load-use hazard)
- redirect  input  1  execute resolved a taken branch/jump this cycle
- redirect_pc  input  ADDR_WIDTH  target PC for redirect
- imem_addr  output  ADDR_WIDTH  instruction-memory address (= current PC, combinational from PC register)
- imem_rdata  input  INSTR_WIDTH  instruction word, combinational read of imem_addr
- id_instr  output  INSTR_WIDTH  IF/ID instruction, to decoder (op = id_instr[6:0])
- id_pc  output  ADDR_WIDTH  PC of id_instr
- id_pc_plus4  output  ADDR_WIDTH  id_pc + 4 (for JAL/JALR link)
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- fetch_misaligned  output  1  sticky: a redirect target had bits [1:0] ≠ 0
- fetch_count  output  32  count of instructions loaded into IF/ID with id_valid=1

## Operation
- PC register pc_f; imem_addr = pc_f.
- Per cycle, priority rst > redirect > stall > normal:
  - rst: pc_f ← RESET_PC; id_instr ← NOP (32'h0000_0013, addi x0,x0,0); id_pc ← 0; id_pc_plus4 ← 0; id_valid ← 0; fetch_misaligned ← 0; fetch_count ← 0.
  - redirect: pc_f ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; IF/ID ← bubble (NOP, valid 0, id_pc/id_pc_plus4 hold); overrides stall. If redirect_pc[1:0] ≠ 0, fetch_misaligned ← 1 (sticky until rst).
  - stall (no redirect): pc_f, IF/ID, fetch_count all hold.
  - normal: pc_f ← pc_f + 4; id_instr ← imem_rdata; id_pc ← pc_f; id_pc_plus4 ← pc_f + 4; id_valid ← 1; fetch_count ← fetch_count + 1.
- PC arithmetic modulo 2^ADDR_WIDTH; pc_f = all-ones−3 increments to 0 with no flag.
- fetch_count wraps 2^32−1 → 0 silently.
- Bubble is a real NOP so the decoder's Type_I_ALU path writes x0 only; id_valid lets downstream suppress it from counters/retire.

## Timing
- Fetch latency: instruction at PC p visible on id_instr one cycle after pc_f = p with no stall/redirect.
- Redirect asserted cycle N: cycle N+1 shows bubble in IF/ID and pc_f = target; target instruction in IF/ID at N+2. Exactly one bubble per redirect (the second wrong-path slot is killed by execute's own flush, not here).
- Stall held k cycles: IF/ID and pc_f frozen k cycles; no instruction lost or duplicated on release.
- Redirect and stall same cycle: redirect wins, stall ignored.
- rst asserted mid-stream (any state): next edge applies reset values; first valid instruction (from RESET_PC) appears in IF/ID the cycle after rst deasserts.
- Back-to-back redirects: each applies; last one defines pc_f.

## Structure
- Shared package (cpu_pkg): NOP_INSTR constant, RESET_PC default, RV32I opcode enum (shared with main_decoder).
- One natural sub-module: if_id_reg (IF/ID register with load/hold/bubble controls, owns id_instr/id_pc/id_pc_plus4/id_valid). PC logic and counter stay in fetch_stage.

## Test plan
- Reset then free-run, imem returns 32'h0010_0093 at 0, 32'h0020_0113 at 4: id_instr = 0x00100093 with id_pc=0, id_valid=1 in cycle 1 after rst; next cycle 0x00200113, id_pc=4, id_pc_plus4=8; fetch_count=2.
- Stall high 3 cycles at pc_f=8: imem_addr stays 8, IF/ID unchanged 3 cycles, fetch_count unchanged; release → instruction at 8 enters IF/ID.
- Redirect to 0x40 while stall=1: next cycle id_valid=0, id_instr=0x00000013, pc_f=0x40; following cycle id_pc=0x40, id_valid=1.
- Redirect to 0x42: pc_f=0x40, fetch_misaligned=1 and stays 1 through later normal fetches until rst.
- rst pulsed while stall and redirect both high: all outputs at reset values, pc_f=RESET_PC, fetch_misaligned=0.
- Preload fetch_count near wrap via 2^32−1 fetches (or forced): next valid fetch → fetch_count=0; pc_f=0xFFFF_FFFC normal fetch → pc_f=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: bubble instruction, default reset vector and base opcodes.
// Imported by the fetch stage and the main decoder.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpFence  = 7'b0001111,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } opcode_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > bubble > load > hold.
// A bubble inserts a real NOP and clears valid while keeping the PC fields.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bubble,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [ADDR_WIDTH-1:0]  pc_plus4,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [ADDR_WIDTH-1:0]  id_pc_plus4,
  output logic                   id_valid
);

  localparam logic [INSTR_WIDTH-1:0] Nop = INSTR_WIDTH'(NOP_INSTR);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pc_plus4_q, pc_plus4_d;
  logic                   valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble) begin
      instr_d = Nop;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr;
      pc_d       = pc;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= Nop;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign id_instr    = instr_q;
  assign id_pc       = pc_q;
  assign id_pc_plus4 = pc_plus4_q;
  assign id_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, drives imem, fills IF/ID.
// Priority per cycle is rst > redirect > stall > normal fetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [ADDR_WIDTH-1:0]  id_pc_plus4,
  output logic                   id_valid,
  output logic                   fetch_misaligned,
  output logic [31:0]            fetch_count
);

  logic [ADDR_WIDTH-1:0] pc_f_q, pc_f_d, pc_plus4;
  logic                  misaligned_q, misaligned_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic                  load;

  assign pc_plus4 = pc_f_q + ADDR_WIDTH'(4);
  assign load     = !redirect && !stall;

  always_comb begin
    pc_f_d        = pc_f_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      // Target is forced word-aligned; the low bits only raise the sticky flag.
      pc_f_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      if (!is_word_aligned(redirect_pc[1:0])) misaligned_d = 1'b1;
    end else if (load) begin
      pc_f_d        = pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .bubble      (redirect),
    .instr       (imem_rdata),
    .pc          (pc_f_q),
    .pc_plus4    (pc_plus4),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid)
  );

  assign imem_addr        = pc_f_q;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic,
// each cycle compared against a transaction-level fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_valid, fetch_misaligned;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr[9:2]];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_count;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_pc_plus4      (id_pc_plus4),
    .id_valid         (id_valid),
    .fetch_misaligned (fetch_misaligned),
    .fetch_count      (fetch_count)
  );

  function automatic logic [161:0] dut_vec();
    return {imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_misaligned, fetch_count};
  endfunction

  function automatic logic [161:0] model_vec();
    return {m_pc, m_instr, m_idpc, m_idpc4, m_valid, m_mis, m_count};
  endfunction

  // Apply inputs, clock once, advance the model, settle 1ns past the edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0000_0013; m_idpc = 0; m_idpc4 = 0;
      m_valid = 0; m_mis = 0; m_count = 0;
    end else if (rd) begin
      m_pc = rpc & ~32'h3; m_instr = 32'h0000_0013; m_valid = 0;
      if (rpc[1:0] != 2'b00) m_mis = 1;
    end else if (!s) begin
      m_instr = mem[m_pc[9:2]]; m_idpc = m_pc; m_idpc4 = m_pc + 4;
      m_valid = 1; m_count = m_count + 1; m_pc = m_pc + 4;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    checks++;
    if ({imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_misaligned, fetch_count}
        !== {32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_basic_fetch();
    step(0, 0, 0, 0);
    checks++;
    if ({id_instr, id_pc, id_valid, fetch_count} !== {32'h0010_0093, 32'h0, 1'b1, 32'd1}) begin
      failures++;
      $display("FAIL first_fetch got=%h %h %b %0d exp=00100093 0 1 1",
               id_instr, id_pc, id_valid, fetch_count);
    end
    step(0, 0, 0, 0);
    checks++;
    if ({id_instr, id_pc, id_pc_plus4, fetch_count, imem_addr}
        !== {32'h0020_0113, 32'h4, 32'h8, 32'd2, 32'h8}) begin
      failures++;
      $display("FAIL second_fetch got=%h %h %h %0d %h exp=00200113 4 8 2 8",
               id_instr, id_pc, id_pc_plus4, fetch_count, imem_addr);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if ({imem_addr, id_instr, id_pc, fetch_count} !== {32'h8, 32'h0020_0113, 32'h4, 32'd2}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if ({id_instr, id_pc, id_valid, fetch_count} !== {mem[2], 32'h8, 1'b1, 32'd3}) begin
      failures++;
      $display("FAIL stall_release got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_redirect_over_stall();
    step(0, 1, 1, 32'h40);
    checks++;
    if ({id_valid, id_instr, imem_addr} !== {1'b0, 32'h0000_0013, 32'h40}) begin
      failures++;
      $display("FAIL redirect_bubble got=%b %h %h exp=0 00000013 00000040",
               id_valid, id_instr, imem_addr);
    end
    step(0, 0, 0, 0);
    checks++;
    if ({id_pc, id_valid, id_instr} !== {32'h40, 1'b1, mem[16]}) begin
      failures++;
      $display("FAIL redirect_target got=%h %b %h exp=00000040 1 %h", id_pc, id_valid, id_instr,
               mem[16]);
    end
  endtask

  task automatic test_misaligned();
    step(0, 0, 1, 32'h42);
    checks++;
    if ({imem_addr, fetch_misaligned} !== {32'h40, 1'b1}) begin
      failures++;
      $display("FAIL misaligned_redirect got=%h %b exp=00000040 1", imem_addr, fetch_misaligned);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (fetch_misaligned !== 1'b1 || dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL misaligned_sticky cycle=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h123);
    checks++;
    if ({imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fetch_misaligned, fetch_count}
        !== {32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_midstream got=%h exp=%h", dut_vec(), model_vec());
    end
    step(0, 0, 0, 0);
    checks++;
    if ({id_instr, id_pc, id_valid} !== {32'h0010_0093, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_refetch got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    checks++;
    if ({imem_addr, id_pc, id_pc_plus4} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL pc_wrap got=%h %h %h exp=00000000 fffffffc 00000000",
               imem_addr, id_pc, id_pc_plus4);
    end
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_count = 32'hFFFF_FFFF;
    step(0, 0, 0, 0);
    checks++;
    if (fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL count_wrap got=%h exp=00000000", fetch_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic        r, s, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 1) == 1) rpc[1:0] = 2'b00;
      step(r, s, rd, rpc);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random cycle=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    m_pc = 0; m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_mis = 0; m_count = 0;
    #1;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_over_stall();
    test_misaligned();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
